// File: rtl/m_dmem_resp_pkg.sv
// Shared definitions for the data-memory responder: state encoding and the
// byte-enable constant.
package m_dmem_resp_pkg;

  localparam logic [2:0] DMR_S_IDLE = 3'd0;
  localparam logic [2:0] DMR_S_WAIT = 3'd1;
  localparam logic [2:0] DMR_S_RESP = 3'd2;

  localparam logic [3:0] DMR_BE_ALL = 4'hf;

  typedef enum logic [2:0] {
    S_IDLE = DMR_S_IDLE,
    S_WAIT = DMR_S_WAIT,
    S_RESP = DMR_S_RESP
  } dmr_state_e;

endpackage

// File: rtl/m_dmem_resp_bram.sv
// DEPTH x 32 synchronous RAM with per-byte write enables and a registered
// read-before-write output; w_clr forces the read word to zero.
module m_bram_be #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic          w_clk,
  input  logic          w_rst_n,
  input  logic          w_en,
  input  logic          w_clr,
  input  logic [3:0]    w_we,
  input  logic [AW-1:0] w_addr,
  input  logic [31:0]   w_wdata,
  output logic [31:0]   r_rdata
);

  logic [31:0] mem [DEPTH];

  // Array storage carries no reset so it maps onto block RAM.
  always_ff @(posedge w_clk) begin
    if (w_en && !w_clr) begin
      for (int i = 0; i < 4; i++) begin
        if (w_we[i]) mem[w_addr][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge w_clk) begin
    if (!w_rst_n)  r_rdata <= '0;
    else if (w_en) r_rdata <= w_clr ? '0 : mem[w_addr];
  end

endmodule

// File: rtl/m_dmem_resp.sv
// Data-memory responder: valid/ready request and response channels in front
// of a byte-enable RAM, with LATENCY wait cycles and out-of-range errors.
//
// state  | meaning
// S_IDLE | ready for a request; LATENCY=0 accesses on the accept edge
// S_WAIT | counting down wait cycles; access on the terminal-count edge
// S_RESP | response held until the master takes it
module m_dmem_resp
  import m_dmem_resp_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 2
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              w_req_valid,
  output logic              r_req_ready,
  input  logic              w_req_we,
  input  logic [ADDR_W-1:0] w_req_addr,
  input  logic [31:0]       w_req_wdata,
  input  logic [3:0]        w_req_be,
  output logic              r_rsp_valid,
  input  logic              w_rsp_ready,
  output logic [31:0]       r_rsp_rdata,
  output logic              r_rsp_we,
  output logic              r_rsp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY);

  // The wait counter is 4 bits wide.
  if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
    $error("m_dmem_resp: LATENCY must be in 0..15");
  end

  dmr_state_e        state;
  logic [3:0]        cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;

  logic              accept;
  logic              access;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic [3:0]        acc_be;
  logic              in_range;

  assign accept = (state == S_IDLE) && w_req_valid && r_req_ready;

  // With zero latency the access uses the live request on the accept edge.
  assign acc_we    = (state == S_IDLE) ? w_req_we    : we_q;
  assign acc_addr  = (state == S_IDLE) ? w_req_addr  : addr_q;
  assign acc_wdata = (state == S_IDLE) ? w_req_wdata : wdata_q;
  assign acc_be    = (state == S_IDLE) ? w_req_be    : be_q;

  assign in_range = 32'(acc_addr) < 32'(DEPTH);
  assign access   = w_rst_n && ((accept && (LATENCY == 0)) ||
                                ((state == S_WAIT) && (cnt == 4'd1)));

  always_ff @(posedge w_clk) begin
    if (w_rst_n && accept) begin
      we_q    <= w_req_we;
      addr_q  <= w_req_addr;
      wdata_q <= w_req_wdata;
      be_q    <= w_req_be;
    end
  end

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_we    <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt         <= CNT_LOAD;
            r_req_ready <= 1'b0;
            if (LATENCY == 0) begin
              state       <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_we    <= w_req_we;
              r_rsp_err   <= !in_range;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state       <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_we    <= we_q;
            r_rsp_err   <= !in_range;
          end
        end
        S_RESP: begin
          if (w_rsp_ready) begin
            state       <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: begin
          state       <= S_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  m_bram_be #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .w_en    (access),
    .w_clr   (!in_range),
    .w_we    ((acc_we && in_range) ? acc_be : 4'b0000),
    .w_addr  (acc_addr[AW-1:0]),
    .w_wdata (acc_wdata),
    .r_rdata (r_rsp_rdata)
  );

endmodule

// File: tb/tb_m_dmem_resp.sv
// Randomized bench for m_dmem_resp: two instances (LATENCY=2/DEPTH=16 and
// LATENCY=0/DEPTH=40) checked against a word-array memory model.
module tb_m_dmem_resp;
  import m_dmem_resp_pkg::*;

  localparam int NI = 2;
  localparam int AW = 6;
  localparam int LAT [NI] = '{2, 0};
  localparam int DEP [NI] = '{16, 40};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid [NI];
  logic          req_ready [NI];
  logic          req_we    [NI];
  logic [AW-1:0] req_addr  [NI];
  logic [31:0]   req_wdata [NI];
  logic [3:0]    req_be    [NI];
  logic          rsp_valid [NI];
  logic          rsp_ready [NI];
  logic [31:0]   rsp_rdata [NI];
  logic          rsp_we    [NI];
  logic          rsp_err   [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    m_dmem_resp #(.ADDR_W(AW), .DEPTH(DEP[g]), .LATENCY(LAT[g])) u_dut (
      .w_clk       (clk),
      .w_rst_n     (rst_n),
      .w_req_valid (req_valid[g]),
      .r_req_ready (req_ready[g]),
      .w_req_we    (req_we[g]),
      .w_req_addr  (req_addr[g]),
      .w_req_wdata (req_wdata[g]),
      .w_req_be    (req_be[g]),
      .r_rsp_valid (rsp_valid[g]),
      .w_rsp_ready (rsp_ready[g]),
      .r_rsp_rdata (rsp_rdata[g]),
      .r_rsp_we    (rsp_we[g]),
      .r_rsp_err   (rsp_err[g])
    );
  end

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] model [NI][64];
  logic [31:0] last_rd;
  logic        last_err;
  int          prev_k = -1;
  bit          prev_fast = 0;
  int          last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input int k);
    chk($sformatf("rst_req_ready%0d", k), 32'(req_ready[k]), 1);
    chk($sformatf("rst_rsp_valid%0d", k), 32'(rsp_valid[k]), 0);
    chk($sformatf("rst_rsp_rdata%0d", k), rsp_rdata[k], 0);
    chk($sformatf("rst_rsp_we%0d", k), 32'(rsp_we[k]), 0);
    chk($sformatf("rst_rsp_err%0d", k), 32'(rsp_err[k]), 0);
  endtask

  // Called #1 after a posedge; returns #1 after the response handshake edge.
  task automatic txn(input int k, input bit we, input logic [AW-1:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int hold);
    logic [31:0] exp_rd;
    bit          exp_err;
    int          waited;
    int          acc_cyc;
    exp_err = (int'(addr) >= DEP[k]);
    exp_rd  = exp_err ? 32'h0 : model[k][addr];
    chk($sformatf("idle_ready%0d", k), 32'(req_ready[k]), 1);
    req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = addr;
    req_wdata[k] = wdata; req_be[k] = be;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    req_valid[k] = 1'b0; req_we[k] = 1'($urandom); req_addr[k] = AW'($urandom);
    req_wdata[k] = $urandom; req_be[k] = 4'($urandom);
    if (prev_k == k && prev_fast)
      chk($sformatf("spacing%0d", k), 32'(acc_cyc - last_acc), 32'(2 + LAT[k]));
    waited = 0;
    while (!rsp_valid[k] && waited < 40) begin
      chk($sformatf("wait_ready%0d", k), 32'(req_ready[k]), 0);
      @(posedge clk);
      #1;
      waited++;
    end
    chk($sformatf("latency%0d", k), 32'(waited), 32'(LAT[k]));
    chk($sformatf("rsp_valid%0d", k), 32'(rsp_valid[k]), 1);
    chk($sformatf("rsp_rdata%0d@%0d", k, addr), rsp_rdata[k], exp_rd);
    chk($sformatf("rsp_we%0d", k), 32'(rsp_we[k]), 32'(we));
    chk($sformatf("rsp_err%0d@%0d", k, addr), 32'(rsp_err[k]), 32'(exp_err));
    chk($sformatf("rsp_ready_low%0d", k), 32'(req_ready[k]), 0);
    last_rd  = rsp_rdata[k];
    last_err = rsp_err[k];
    // Stray requests during backpressure are stores that must not land.
    for (int i = 0; i < hold; i++) begin
      req_valid[k] = 1'b1; req_we[k] = 1'b1; req_addr[k] = AW'($urandom);
      req_wdata[k] = $urandom; req_be[k] = DMR_BE_ALL;
      @(posedge clk);
      #1;
      req_valid[k] = 1'b0;
      chk($sformatf("hold_valid%0d", k), 32'(rsp_valid[k]), 1);
      chk($sformatf("hold_rdata%0d", k), rsp_rdata[k], exp_rd);
      chk($sformatf("hold_ready%0d", k), 32'(req_ready[k]), 0);
    end
    rsp_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[k] = 1'b0;
    chk($sformatf("done_valid%0d", k), 32'(rsp_valid[k]), 0);
    chk($sformatf("done_ready%0d", k), 32'(req_ready[k]), 1);
    if (we && !exp_err)
      for (int i = 0; i < 4; i++)
        if (be[i]) model[k][addr][8*i +: 8] = wdata[8*i +: 8];
    prev_k    = k;
    prev_fast = (hold == 0);
    last_acc  = acc_cyc;
  endtask

  initial begin
    logic [31:0] prior;
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      req_valid[k] = 1'b0; rsp_ready[k] = 1'b0; req_we[k] = 1'b0;
      req_addr[k] = '0; req_wdata[k] = '0; req_be[k] = '0;
      for (int a = 0; a < 64; a++) model[k][a] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) chk_reset_vals(k);

    // Give every implemented word a known value; addr 5 starts at zero.
    for (int k = 0; k < NI; k++)
      for (int a = 0; a < DEP[k]; a++)
        txn(k, 1'b1, AW'(a), (a == 5) ? 32'h0 : $urandom, DMR_BE_ALL, 0);

    txn(0, 1'b1, 6'd5, 32'hdeadbeef, 4'hf, 0);
    chk("tp_store_old", last_rd, 32'h0);
    txn(0, 1'b0, 6'd5, 32'h0, 4'h0, 0);
    chk("tp_load_deadbeef", last_rd, 32'hdeadbeef);
    txn(0, 1'b1, 6'd5, 32'h11223344, 4'b0101, 0);
    txn(0, 1'b0, 6'd5, 32'h0, 4'h0, 5);
    chk("tp_partial", last_rd, 32'hde22be44);

    txn(1, 1'b0, 6'd0, 32'h0, 4'h0, 0);
    txn(1, 1'b0, 6'd1, 32'h0, 4'h0, 0);

    prior = model[0][4];
    txn(0, 1'b1, 6'd20, 32'hcafef00d, 4'hf, 0);
    chk("tp_oor_err", 32'(last_err), 1);
    chk("tp_oor_rdata", last_rd, 32'h0);
    txn(0, 1'b0, 6'd4, 32'h0, 4'h0, 0);
    chk("tp_alias_kept", last_rd, prior);

    // Reset on the edge the LATENCY=2 store would commit.
    prior = model[0][7];
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 6'd7;
    req_wdata[0] = 32'h5; req_be[0] = 4'hf;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_reset_vals(0);
    prev_k = -1;
    txn(0, 1'b0, 6'd7, 32'h0, 4'h0, 0);
    chk("tp_rst_wait_old", last_rd, prior);

    // Reset coinciding with a request edge: nothing is latched or written.
    for (int k = 0; k < NI; k++) begin
      req_valid[k] = 1'b1; req_we[k] = 1'b1; req_addr[k] = 6'd3;
      req_wdata[k] = 32'h0badf00d; req_be[k] = 4'hf;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < NI; k++) req_valid[k] = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) begin
        chk($sformatf("rst_hs_valid%0d", k), 32'(rsp_valid[k]), 0);
        chk($sformatf("rst_hs_ready%0d", k), 32'(req_ready[k]), 1);
      end
    end
    prev_k = -1;
    for (int k = 0; k < NI; k++) txn(k, 1'b0, 6'd3, 32'h0, 4'h0, 0);

    for (int n = 0; n < 120; n++)
      txn($urandom_range(0, NI - 1), 1'($urandom), AW'($urandom_range(0, 63)),
          $urandom, 4'($urandom), $urandom_range(0, 3));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
